// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared types and defaults for the sequential TNN wrappers
// Contents: scheduler state encoding, default core dimensions, class-index width helper.
package tnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE,
      ST_HOLD
   } state_t;

   localparam int N_DEF = 128;
   localparam int M_DEF = 40;
   localparam int B_DEF = 4;
   localparam int C_DEF = 6;

   // Width needed to carry a class index; a single-class core still needs one bit.
   function automatic int klass_width(input int c);
      return (c <= 1) ? 1 : $clog2(c);
   endfunction

endpackage

// File: rtl/tnn_seq_sched_if.sv
// rtl/tnn_seq_sched_if.sv - sample-in / result-out handshake bundle for tnn_seq_sched
// Signals: in_valid/in_ready/in_data (sample stream), out_valid/out_ready/out_klass (result stream).
// Modports: master = sample source / result consumer, slave = scheduler.
interface tnn_seq_sched_if #(
   parameter int DW = tnn_pkg::B_DEF * tnn_pkg::N_DEF,
   parameter int KW = tnn_pkg::klass_width(tnn_pkg::C_DEF)
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [KW-1:0] out_klass;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_klass
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_klass
   );

endinterface

// File: rtl/tnn_lat_counter.sv
// rtl/tnn_lat_counter.sv - fixed-latency counter with start and terminal-count flag
// Ports: clk, rst (async, active-high), start (reload), en (count), tc (terminal count reached).
// Up mode counts 0..LAST, down mode counts LAST..0; tc flags the last value either way.
module tnn_lat_counter #(
   parameter int W    = 8,
   parameter int LAST = 1,
   parameter bit DOWN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   output logic tc
);

   localparam logic [W-1:0] LAST_W = W'(LAST);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= DOWN ? LAST_W : '0;
      end else if (en) begin
         cnt <= DOWN ? (cnt - W'(1)) : (cnt + W'(1));
      end
   end

   assign tc = DOWN ? (cnt == '0) : (cnt == LAST_W);

endmodule

// File: rtl/tnn_seq_sched.sv
// rtl/tnn_seq_sched.sv - start/done sequencer for a handshake-less bit-serial ternary classifier
// Ports: clk, rst (async, active-high); bus (slave: sample in, class index out);
//        busy (LOAD/RUN), core_data/core_rst to the core, core_klass from the core,
//        done_cnt (completed classifications, wrapping).
module tnn_seq_sched
   import tnn_pkg::*;
#(
   parameter  int N   = N_DEF,
   parameter  int M   = M_DEF,
   parameter  int B   = B_DEF,
   parameter  int C   = C_DEF,
   parameter  int LAT = N + M,
   localparam int KW  = klass_width(C)
) (
   input  logic            clk,
   input  logic            rst,
   tnn_seq_sched_if.slave  bus,
   output logic            busy,
   output logic [B*N-1:0]  core_data,
   output logic            core_rst,
   input  logic [KW-1:0]   core_klass,
   output logic [15:0]     done_cnt
);

   // Wide enough for LAT-1 with headroom so the count never wraps inside RUN.
   localparam int CW = $clog2(LAT + 1);

   state_t          state;
   state_t          state_n;
   logic [B*N-1:0]  data_q;
   logic [KW-1:0]   klass_q;
   logic            cnt_start;
   logic            cnt_en;
   logic            cnt_tc;
   logic            accept;

   // Every handshake output is a pure decode of state, so no input reaches an output combinationally.
   assign bus.in_ready  = (state == ST_IDLE) || (state == ST_DONE);
   assign bus.out_valid = (state == ST_DONE) || (state == ST_HOLD);
   assign bus.out_klass = klass_q;
   assign busy          = (state == ST_LOAD) || (state == ST_RUN);
   assign core_rst      = (state != ST_RUN);
   assign core_data     = data_q;

   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_start = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.in_valid) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_start = 1'b1;
            state_n   = ST_RUN;
         end
         ST_RUN: begin
            cnt_en = 1'b1;
            if (cnt_tc) state_n = ST_DONE;
         end
         ST_DONE: begin
            // A sample accepted while the result is still pending parks in HOLD.
            if (bus.out_ready) begin
               state_n = bus.in_valid ? ST_LOAD : ST_IDLE;
            end else if (bus.in_valid) begin
               state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) state_n = ST_LOAD;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   tnn_lat_counter #(
      .W    (CW),
      .LAST (LAT - 1),
      .DOWN (1'b0)
   ) u_lat_counter (
      .clk   (clk),
      .rst   (rst),
      .start (cnt_start),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         klass_q  <= '0;
         done_cnt <= '0;
      end else begin
         // core_data only moves on an accepting edge, so it is stable through LOAD and RUN.
         if (accept) begin
            data_q <= bus.in_data;
         end
         if ((state == ST_RUN) && cnt_tc) begin
            klass_q  <= core_klass;
            done_cnt <= done_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tnn_seq_sched.sv
// tb/tb_tnn_seq_sched.sv - directed self-checking bench for tnn_seq_sched
module tb_tnn_seq_sched;
   import tnn_pkg::*;

   localparam int DW  = B_DEF * N_DEF;
   localparam int KW  = klass_width(C_DEF);
   localparam int LAT = N_DEF + M_DEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- default-latency DUT ----------------
   tnn_seq_sched_if #(.DW(DW), .KW(KW)) bus ();
   logic          busy;
   logic [DW-1:0] core_data;
   logic          core_rst;
   logic [KW-1:0] core_klass;
   logic [15:0]   done_cnt;

   tnn_seq_sched dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .core_data  (core_data),
      .core_rst   (core_rst),
      .core_klass (core_klass),
      .done_cnt   (done_cnt)
   );

   // Stub core: correct class only in cycle LAT after core_rst falls, a wrong value otherwise.
   logic [KW-1:0] stub_val = '0;
   int            rc = 0;
   always @(posedge clk) if (core_rst) rc <= 0; else rc <= rc + 1;
   assign core_klass = (!core_rst && rc == LAT - 1) ? stub_val : ~stub_val;

   // ---------------- LAT=1 DUT ----------------
   tnn_seq_sched_if #(.DW(DW), .KW(KW)) bus1 ();
   logic          busy1;
   logic [DW-1:0] core_data1;
   logic          core_rst1;
   logic [KW-1:0] core_klass1;
   logic [15:0]   done_cnt1;

   tnn_seq_sched #(.LAT(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus1),
      .busy       (busy1),
      .core_data  (core_data1),
      .core_rst   (core_rst1),
      .core_klass (core_klass1),
      .done_cnt   (done_cnt1)
   );

   logic [KW-1:0] stub1_val = '0;
   int            rc1 = 0;
   always @(posedge clk) if (core_rst1) rc1 <= 0; else rc1 <= rc1 + 1;
   assign core_klass1 = (!core_rst1 && rc1 == 0) ? stub1_val : ~stub1_val;

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns edges from accept to out_valid and core_rst-low cycles.
   task automatic send_wait(input logic [DW-1:0] v, input logic [KW-1:0] kl,
                            output int lat, output int low);
      int t;
      bit seen;
      seen = 1'b0;
      low  = 0;
      stub_val     = kl;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      t = cyc + 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      expect_eq("load_busy", busy, 1);
      expect_eq("load_core_rst", core_rst, 1);
      expect_eq("load_core_data", core_data == v, 1);
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (!core_rst) low++;
         if (bus.out_valid) seen = 1'b1;
      end
      lat = cyc - t;
      expect_eq("result_seen", seen, 1);
   endtask

   logic [DW-1:0] vec [5];
   logic [KW-1:0] kl  [5];
   int            res_cyc [5];
   logic [KW-1:0] res_kl  [5];
   int            lat, low, idx, nres, gaps, bad, t, ov_cnt;
   bit            started, seen;
   logic [DW-1:0] va, vb, vc, vd;

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset values
      expect_eq("rst_in_ready", bus.in_ready, 1);
      expect_eq("rst_out_valid", bus.out_valid, 0);
      expect_eq("rst_out_klass", bus.out_klass, 0);
      expect_eq("rst_busy", busy, 0);
      expect_eq("rst_core_rst", core_rst, 1);
      expect_eq("rst_core_data", core_data == '0, 1);
      expect_eq("rst_done_cnt", done_cnt, 0);

      // single sample
      va = rand_vec();
      send_wait(va, 3, lat, low);
      expect_eq("single_latency", lat, LAT + 1);
      expect_eq("single_core_rst_low", low, LAT);
      expect_eq("single_klass", bus.out_klass, 3);
      expect_eq("single_done_cnt", done_cnt, 1);
      expect_eq("single_in_ready", bus.in_ready, 1);
      expect_eq("single_busy", busy, 0);
      @(negedge clk);
      expect_eq("single_hold_valid", bus.out_valid, 1);
      expect_eq("single_hold_klass", bus.out_klass, 3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      expect_eq("single_after_hs_valid", bus.out_valid, 0);
      expect_eq("single_after_hs_in_ready", bus.in_ready, 1);

      // back-to-back with a ready consumer
      do_reset();
      kl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < 5; i++) vec[i] = rand_vec();
      bus.out_ready = 1'b1;
      idx = 0; nres = 0; gaps = 0; started = 1'b0;
      for (int i = 0; i < 1500 && nres < 5; i++) begin
         bus.in_valid = (idx < 5);
         bus.in_data  = vec[(idx < 5) ? idx : 0];
         if (bus.out_valid) begin
            res_cyc[nres] = cyc;
            res_kl[nres]  = bus.out_klass;
            nres++;
         end else if (started && !busy) begin
            gaps++;
         end
         if (bus.in_valid && bus.in_ready) begin
            stub_val = kl[idx];
            idx++;
            started = 1'b1;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      expect_eq("b2b_results", nres, 5);
      for (int i = 0; i < 5; i++) expect_eq($sformatf("b2b_klass_%0d", i), res_kl[i], kl[i]);
      for (int i = 1; i < 5; i++)
         expect_eq($sformatf("b2b_spacing_%0d", i), res_cyc[i] - res_cyc[i-1], LAT + 2);
      expect_eq("b2b_idle_gaps", gaps, 0);
      expect_eq("b2b_done_cnt", done_cnt, 5);
      bus.out_ready = 1'b0;

      // backpressure: second sample parks in HOLD
      do_reset();
      va = rand_vec(); vb = rand_vec(); vc = rand_vec();
      send_wait(va, 2, lat, low);
      expect_eq("bp_first_latency", lat, LAT + 1);
      stub_val     = 3'd5;
      bus.in_valid = 1'b1;
      bus.in_data  = vb;
      @(negedge clk);
      bus.in_data  = vc;
      expect_eq("bp_hold_in_ready", bus.in_ready, 0);
      expect_eq("bp_hold_out_valid", bus.out_valid, 1);
      expect_eq("bp_hold_klass", bus.out_klass, 2);
      expect_eq("bp_hold_core_data", core_data == vb, 1);
      bad = 0;
      repeat (49) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
             bus.out_klass !== 3'd2 || core_data !== vb) bad++;
      end
      expect_eq("bp_hold_stable", bad, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      t = cyc + 1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      expect_eq("bp_load_busy", busy, 1);
      expect_eq("bp_load_core_rst", core_rst, 1);
      expect_eq("bp_load_out_valid", bus.out_valid, 0);
      expect_eq("bp_load_core_data", core_data == vb, 1);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      expect_eq("bp_second_seen", seen, 1);
      expect_eq("bp_second_latency", cyc - t, LAT + 1);
      expect_eq("bp_second_klass", bus.out_klass, 5);
      expect_eq("bp_done_cnt", done_cnt, 2);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // reset in the middle of RUN (cnt=100)
      do_reset();
      vd = rand_vec();
      stub_val     = 3'd1;
      bus.in_valid = 1'b1;
      bus.in_data  = vd;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (101) @(negedge clk);
      expect_eq("mid_run_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      expect_eq("mid_rst_in_ready", bus.in_ready, 1);
      expect_eq("mid_rst_out_valid", bus.out_valid, 0);
      expect_eq("mid_rst_core_rst", core_rst, 1);
      expect_eq("mid_rst_busy", busy, 0);
      expect_eq("mid_rst_done_cnt", done_cnt, 0);
      expect_eq("mid_rst_core_data", core_data == '0, 1);
      @(negedge clk);
      rst = 1'b0;
      ov_cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.out_valid) ov_cnt++;
      end
      expect_eq("mid_rst_no_result", ov_cnt, 0);
      send_wait(rand_vec(), 1, lat, low);
      expect_eq("post_rst_latency", lat, LAT + 1);
      expect_eq("post_rst_core_rst_low", low, LAT);
      expect_eq("post_rst_klass", bus.out_klass, 1);
      expect_eq("post_rst_done_cnt", done_cnt, 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // LAT=1 instance: single then back-to-back through DONE
      for (int s = 0; s < 2; s++) begin
         stub1_val     = (s == 0) ? 3'd4 : 3'd5;
         bus1.in_valid = 1'b1;
         bus1.in_data  = rand_vec();
         bus1.out_ready = (s == 1);
         t = cyc + 1;
         @(negedge clk);
         bus1.in_valid  = 1'b0;
         bus1.out_ready = 1'b0;
         expect_eq($sformatf("lat1_load_busy_%0d", s), busy1, 1);
         low = 0; seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!core_rst1) low++;
            if (bus1.out_valid) seen = 1'b1;
         end
         expect_eq($sformatf("lat1_seen_%0d", s), seen, 1);
         expect_eq($sformatf("lat1_latency_%0d", s), cyc - t, 2);
         expect_eq($sformatf("lat1_core_rst_low_%0d", s), low, 1);
         expect_eq($sformatf("lat1_klass_%0d", s), bus1.out_klass, stub1_val);
         expect_eq($sformatf("lat1_done_cnt_%0d", s), done_cnt1, s + 1);
      end
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      expect_eq("lat1_final_idle", bus1.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
